// File: rtl/page_walk_ctrl_if.sv
// CPU-side and memory-side request/acknowledge bus of the paging controller.
// Latency: none; plain wires.
// Backpressure: req is held until ack on both sides.
interface page_walk_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 13
);
  logic          cpu_req;
  logic          cpu_we;
  logic [DW-1:0] cpu_vaddr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_fault;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  // Controller view: serves the CPU, drives the memory port.
  modport slave (
    input  cpu_req, cpu_we, cpu_vaddr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_fault,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  // Environment view: CPU plus memory model.
  modport master (
    output cpu_req, cpu_we, cpu_vaddr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_fault,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/page_walk_ctrl.sv
// Sequences CPU data accesses through BPR + 4-entry direct-mapped PTE cache.
// Latency (zero-wait mem): hit/unpaged ack @2, miss @3, hit fault @1, miss fault @2.
// Backpressure: cpu_req held until cpu_ack; mem_req held (stable) until mem_ack.
module page_walk_ctrl #(
  parameter int DW    = 16,
  parameter int AW    = 13,
  parameter int VPN_W = 2,
  parameter int OFF_W = 4,
  parameter int PPN_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pg_en,
  input  logic          bpr_load,
  input  logic [DW-1:0] bpr_in,
  output logic          busy,
  page_walk_ctrl_if.slave bus
);
  localparam int NENT = 1 << VPN_W;

  typedef enum logic [1:0] {IDLE, WALK, ACCESS, RESP} state_t;

  state_t          r_state, w_next;
  logic [DW-1:0]   r_bpr;
  logic [NENT-1:0] r_valid;
  logic [DW-1:0]   r_cache [NENT];
  logic            r_we, r_paged, r_fault, r_pg_prev, r_walk_flushed;
  logic [DW-1:0]   r_vaddr, r_wdata, r_pte, r_rdata;
  logic [AW-1:0]   r_walk_addr;

  logic [VPN_W-1:0] w_vpn_in, w_vpn_lat;
  logic [DW-1:0]    w_hit_pte;
  logic             w_hit, w_flush, w_fill, w_walk_done;
  logic             w_unused;

  // PTE[0] = present, PTE[1] = writable.
  function automatic logic f_fault(input logic [1:0] flags, input logic we);
    return !flags[0] || (we && !flags[1]);
  endfunction

  assign w_vpn_in    = bus.cpu_vaddr[OFF_W+VPN_W-1:OFF_W];
  assign w_vpn_lat   = r_vaddr[OFF_W+VPN_W-1:OFF_W];
  assign w_hit_pte   = r_cache[w_vpn_in];
  assign w_hit       = r_valid[w_vpn_in];
  assign w_flush     = bpr_load || (pg_en != r_pg_prev);
  assign w_walk_done = (r_state == WALK) && bus.mem_ack;
  // A walk that saw a flush since it was launched must not repopulate the cache.
  assign w_fill      = w_walk_done && bus.mem_rdata[0] && !r_walk_flushed && !w_flush;
  assign w_unused    = &{1'b0, bus.cpu_vaddr[DW-1:AW], r_vaddr[DW-1:AW],
                         r_bpr[DW-1:AW-VPN_W], r_pte[DW-1:PPN_W+2], r_pte[1:0]};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.cpu_req) begin
        if (!pg_en)     w_next = ACCESS;
        else if (w_hit) w_next = f_fault(w_hit_pte[1:0], bus.cpu_we) ? RESP : ACCESS;
        else            w_next = WALK;
      end
      WALK:    if (bus.mem_ack) w_next = f_fault(bus.mem_rdata[1:0], r_we) ? RESP : ACCESS;
      ACCESS:  if (bus.mem_ack) w_next = RESP;
      default: w_next = IDLE;
    endcase
  end

  // Request capture, PTE latch and read-data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we        <= 1'b0;
      r_paged     <= 1'b0;
      r_fault     <= 1'b0;
      r_vaddr     <= '0;
      r_wdata     <= '0;
      r_pte       <= '0;
      r_rdata     <= '0;
      r_walk_addr <= '0;
    end else begin
      if (r_state == IDLE && bus.cpu_req) begin
        r_we        <= bus.cpu_we;
        r_vaddr     <= bus.cpu_vaddr;
        r_wdata     <= bus.cpu_wdata;
        r_paged     <= pg_en;
        r_pte       <= w_hit_pte;
        r_fault     <= pg_en && w_hit && f_fault(w_hit_pte[1:0], bus.cpu_we);
        // Table base is frozen here so a later bpr_load cannot move an issued walk.
        r_walk_addr <= {r_bpr[AW-VPN_W-1:0], w_vpn_in};
      end
      if (w_walk_done) begin
        r_pte   <= bus.mem_rdata;
        r_fault <= f_fault(bus.mem_rdata[1:0], r_we);
      end
      if (r_state == ACCESS && bus.mem_ack && !r_we) r_rdata <= bus.mem_rdata;
    end
  end

  // BPR, cache contents and flush tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bpr          <= '0;
      r_valid        <= '0;
      r_pg_prev      <= 1'b0;
      r_walk_flushed <= 1'b0;
      for (int i = 0; i < NENT; i++) r_cache[i] <= '0;
    end else begin
      r_pg_prev <= pg_en;
      if (bpr_load) r_bpr <= bpr_in;
      r_walk_flushed <= (r_state == IDLE) ? w_flush : (r_walk_flushed || w_flush);
      if (w_flush) r_valid <= '0;
      else if (w_fill) r_valid[w_vpn_lat] <= 1'b1;
      if (w_fill) r_cache[w_vpn_lat] <= bus.mem_rdata;
    end
  end

  // Outputs decoded from state so reset clears them asynchronously.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.cpu_ack   = 1'b0;
    bus.cpu_fault = 1'b0;
    bus.cpu_rdata = r_rdata;
    busy          = (r_state != IDLE);
    case (r_state)
      WALK: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = r_walk_addr;
      end
      ACCESS: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = r_we;
        bus.mem_wdata = r_wdata;
        bus.mem_addr  = r_paged ?
          {{(AW-PPN_W-OFF_W){1'b0}}, r_pte[PPN_W+1:2], r_vaddr[OFF_W-1:0]} :
          r_vaddr[AW-1:0];
      end
      RESP: begin
        bus.cpu_ack   = 1'b1;
        bus.cpu_fault = r_fault;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_page_walk_ctrl.sv
module tb_page_walk_ctrl;
  logic        clk, rst, pg_en, bpr_load, busy;
  logic [15:0] bpr_in;
  int          n_tests = 0;
  int          n_fail  = 0;

  page_walk_ctrl_if #(.DW(16), .AW(13)) bus();

  page_walk_ctrl dut (
    .clk(clk), .rst(rst), .pg_en(pg_en), .bpr_load(bpr_load),
    .bpr_in(bpr_in), .busy(busy), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [15:0] va, input logic [15:0] wd);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_vaddr = va; bus.cpu_wdata = wd;
  endtask

  task automatic mem(input logic ack, input logic [15:0] rd);
    bus.mem_ack = ack; bus.mem_rdata = rd;
  endtask

  task automatic test_reset();
    rst = 1'b0; pg_en = 1'b0; bpr_load = 1'b0; bpr_in = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_vaddr = '0; bus.cpu_wdata = '0;
    mem(1'b0, '0);
    #1;
    n_tests++;
    if ({busy, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
         bus.cpu_ack, bus.cpu_fault, bus.cpu_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b mreq=%b maddr=%h ack=%b rdata=%h, all must be 0",
               busy, bus.mem_req, bus.mem_addr, bus.cpu_ack, bus.cpu_rdata);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_unpaged();
    req(1'b0, 16'h0123, 16'h0);
    tick();  // cycle 1
    n_tests++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 13'h0123}) begin
      n_fail++; $display("FAIL unpaged_addr: req/we/addr=%b/%b/%h want 1/0/0123",
                         bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    mem(1'b1, 16'hBEEF);
    tick();  // cycle 2
    mem(1'b0, 16'h0);
    n_tests++;
    if ({bus.cpu_ack, bus.cpu_fault, bus.cpu_rdata, bus.mem_req} !== {1'b1, 1'b0, 16'hBEEF, 1'b0}) begin
      n_fail++; $display("FAIL unpaged_ack: ack/fault/rdata/mreq=%b/%b/%h/%b want 1/0/beef/0",
                         bus.cpu_ack, bus.cpu_fault, bus.cpu_rdata, bus.mem_req);
    end
    bus.cpu_req = 1'b0;
    tick();
    n_tests++;
    if ({busy, bus.cpu_ack} !== 2'b00) begin
      n_fail++; $display("FAIL unpaged_idle: busy/ack=%b/%b want 0/0", busy, bus.cpu_ack);
    end
    // Enable paging with BPR=5.
    pg_en = 1'b1; bpr_load = 1'b1; bpr_in = 16'h0005;
    tick();
    bpr_load = 1'b0;
    tick();
  endtask

  task automatic test_miss_hit();
    req(1'b0, 16'h0027, 16'h0);
    tick();  // cycle 1: WALK
    n_tests++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 13'h0016}) begin
      n_fail++; $display("FAIL miss_walk: req/we/addr=%b/%b/%h want 1/0/0016",
                         bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    mem(1'b1, 16'h0037);
    tick();  // cycle 2: ACCESS
    n_tests++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 13'h00D7}) begin
      n_fail++; $display("FAIL miss_access: req/addr=%b/%h want 1/00d7", bus.mem_req, bus.mem_addr);
    end
    mem(1'b1, 16'h1234);
    tick();  // cycle 3
    mem(1'b0, 16'h0);
    n_tests++;
    if ({bus.cpu_ack, bus.cpu_fault, bus.cpu_rdata} !== {1'b1, 1'b0, 16'h1234}) begin
      n_fail++; $display("FAIL miss_ack: ack/fault/rdata=%b/%b/%h want 1/0/1234",
                         bus.cpu_ack, bus.cpu_fault, bus.cpu_rdata);
    end
    bus.cpu_req = 1'b0;
    tick();
    req(1'b0, 16'h0027, 16'h0);
    tick();  // cycle 1: hit, straight to ACCESS
    n_tests++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 13'h00D7}) begin
      n_fail++; $display("FAIL hit_access: req/addr=%b/%h want 1/00d7", bus.mem_req, bus.mem_addr);
    end
    mem(1'b1, 16'h5678);
    tick();  // cycle 2
    mem(1'b0, 16'h0);
    n_tests++;
    if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b1, 16'h5678}) begin
      n_fail++; $display("FAIL hit_ack: ack/rdata=%b/%h want 1/5678", bus.cpu_ack, bus.cpu_rdata);
    end
    bus.cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_faults();
    // Not-present PTE, twice: must walk both times.
    for (int k = 0; k < 2; k++) begin
      req(1'b0, 16'h0013, 16'h0);
      tick();
      n_tests++;
      if ({bus.mem_req, bus.mem_addr} !== {1'b1, 13'h0015}) begin
        n_fail++; $display("FAIL np_walk%0d: req/addr=%b/%h want 1/0015", k, bus.mem_req, bus.mem_addr);
      end
      mem(1'b1, 16'h0000);
      tick();
      mem(1'b0, 16'h0);
      n_tests++;
      if ({bus.cpu_ack, bus.cpu_fault, bus.mem_req} !== 3'b110) begin
        n_fail++; $display("FAIL np_fault%0d: ack/fault/mreq=%b/%b/%b want 1/1/0",
                           k, bus.cpu_ack, bus.cpu_fault, bus.mem_req);
      end
      bus.cpu_req = 1'b0;
      tick();
    end
    // Write to read-only page (miss).
    req(1'b1, 16'h003A, 16'hAAAA);
    tick();
    n_tests++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 13'h0017}) begin
      n_fail++; $display("FAIL wp_walk: req/we/addr=%b/%b/%h want 1/0/0017",
                         bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    mem(1'b1, 16'h0035);
    tick();
    mem(1'b0, 16'h0);
    n_tests++;
    if ({bus.cpu_ack, bus.cpu_fault, bus.mem_req} !== 3'b110) begin
      n_fail++; $display("FAIL wp_fault: ack/fault/mreq=%b/%b/%b want 1/1/0",
                         bus.cpu_ack, bus.cpu_fault, bus.mem_req);
    end
    bus.cpu_req = 1'b0;
    tick();
    // Read of the same page hits the cached read-only PTE.
    req(1'b0, 16'h003A, 16'h0);
    tick();
    n_tests++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 13'h00DA}) begin
      n_fail++; $display("FAIL wp_read_hit: req/addr=%b/%h want 1/00da", bus.mem_req, bus.mem_addr);
    end
    mem(1'b1, 16'h4321);
    tick();
    mem(1'b0, 16'h0);
    n_tests++;
    if ({bus.cpu_ack, bus.cpu_fault, bus.cpu_rdata} !== {1'b1, 1'b0, 16'h4321}) begin
      n_fail++; $display("FAIL wp_read_ack: ack/fault/rdata=%b/%b/%h want 1/0/4321",
                         bus.cpu_ack, bus.cpu_fault, bus.cpu_rdata);
    end
    bus.cpu_req = 1'b0;
    tick();
    // Write again: hit fault acknowledged at cycle 1.
    req(1'b1, 16'h003A, 16'hAAAA);
    tick();
    n_tests++;
    if ({bus.cpu_ack, bus.cpu_fault, bus.mem_req} !== 3'b110) begin
      n_fail++; $display("FAIL hit_fault: ack/fault/mreq=%b/%b/%b want 1/1/0",
                         bus.cpu_ack, bus.cpu_fault, bus.mem_req);
    end
    bus.cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    bpr_load = 1'b1; bpr_in = 16'h0009;
    tick();
    bpr_load = 1'b0;
    req(1'b0, 16'h0027, 16'h0);
    tick();
    n_tests++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 13'h0026}) begin
      n_fail++; $display("FAIL flush_rewalk: req/addr=%b/%h want 1/0026", bus.mem_req, bus.mem_addr);
    end
    mem(1'b1, 16'h0037);
    tick();
    mem(1'b1, 16'h0);
    tick();
    mem(1'b0, 16'h0);
    bus.cpu_req = 1'b0;
    tick();
    // bpr_load during a walk.
    req(1'b0, 16'h0002, 16'h0);
    tick();  // WALK at {9,0}
    bpr_load = 1'b1; bpr_in = 16'h000C;
    tick();
    bpr_load = 1'b0;
    n_tests++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 13'h0024}) begin
      n_fail++; $display("FAIL walk_addr_hold: req/addr=%b/%h want 1/0024", bus.mem_req, bus.mem_addr);
    end
    mem(1'b1, 16'h0007);
    tick();
    n_tests++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 13'h0012}) begin
      n_fail++; $display("FAIL walk_flush_access: req/addr=%b/%h want 1/0012", bus.mem_req, bus.mem_addr);
    end
    mem(1'b1, 16'h0);
    tick();
    mem(1'b0, 16'h0);
    bus.cpu_req = 1'b0;
    tick();
    req(1'b0, 16'h0002, 16'h0);
    tick();
    n_tests++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 13'h0030}) begin
      n_fail++; $display("FAIL walk_not_cached: req/addr=%b/%h want 1/0030", bus.mem_req, bus.mem_addr);
    end
    mem(1'b1, 16'h0007);
    tick();
    mem(1'b1, 16'h9999);
    tick();
    mem(1'b0, 16'h0);
    bus.cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_wait_states();
    req(1'b1, 16'h0002, 16'hCAFE);
    tick();  // hit -> ACCESS
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_ack} !==
          {1'b1, 1'b1, 13'h0012, 16'hCAFE, 1'b0}) begin
        n_fail++; $display("FAIL wait_stable%0d: req/we/addr/wdata/ack=%b/%b/%h/%h/%b want 1/1/0012/cafe/0",
                           i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_ack);
      end
      tick();
    end
    mem(1'b1, 16'h7777);
    tick();
    mem(1'b0, 16'h0);
    n_tests++;
    if ({bus.cpu_ack, bus.cpu_fault, bus.cpu_rdata, bus.mem_req} !== {1'b1, 1'b0, 16'h9999, 1'b0}) begin
      n_fail++; $display("FAIL wait_ack: ack/fault/rdata/mreq=%b/%b/%h/%b want 1/0/9999/0",
                         bus.cpu_ack, bus.cpu_fault, bus.cpu_rdata, bus.mem_req);
    end
    bus.cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    int acks = 0;
    req(1'b0, 16'h0002, 16'h0);
    tick();  // ACCESS
    rst = 1'b0;
    #1;
    n_tests++;
    if ({bus.mem_req, busy, bus.cpu_ack, bus.cpu_rdata} !== {3'b000, 16'h0}) begin
      n_fail++; $display("FAIL rst_async: mreq/busy/ack/rdata=%b/%b/%b/%h want 0/0/0/0",
                         bus.mem_req, busy, bus.cpu_ack, bus.cpu_rdata);
    end
    bus.cpu_req = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.cpu_ack) acks++;
    end
    n_tests++;
    if (acks != 0) begin
      n_fail++; $display("FAIL rst_no_ack: saw %0d acks want 0", acks);
    end
    req(1'b0, 16'h0002, 16'h0);
    tick();
    n_tests++;
    if ({bus.mem_req, busy, bus.mem_addr} !== {1'b1, 1'b1, 13'h0000}) begin
      n_fail++; $display("FAIL rst_cache_bpr: req/busy/addr=%b/%b/%h want 1/1/0000",
                         bus.mem_req, busy, bus.mem_addr);
    end
    mem(1'b1, 16'h0007);
    tick();
    mem(1'b1, 16'h0);
    tick();
    mem(1'b0, 16'h0);
    bus.cpu_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_unpaged();
    test_miss_hit();
    test_faults();
    test_flush();
    test_wait_states();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/page_walk_ctrl.md
Name: page_walk_ctrl

Overview:
- Sequences every CPU data-memory access through the paging datapath.
- Owns the base page register (BPR) and a 4-entry direct-mapped translation cache indexed by virtual page number.
- On a cache miss it fetches the page-table entry (PTE) from memory, then issues the physical access.
- Sits between the microcoded core's MAR/DBus interface and the memory/SDRAM port, replacing the core's ad-hoc memAddr mux.

Parameters:
DW, 16, data/PTE/BPR width
AW, 13, physical memory address width
VPN_W, 2, virtual page number width (vaddr[OFF_W+VPN_W-1:OFF_W])
OFF_W, 4, page offset width (vaddr[OFF_W-1:0])
PPN_W, 4, physical page number width (PTE[PPN_W+1:2])

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-low reset
pg_en  in  1  paging enable; 0 = physical addressing
bpr_load  in  1  load bpr_in into BPR this cycle
bpr_in  in  DW  new page-table base
cpu_req  in  1  access request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_vaddr  in  DW  virtual (or physical when pg_en=0) address
cpu_wdata  in  DW  write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DW  read data, valid with cpu_ack
cpu_fault  out  1  page fault, valid with cpu_ack
busy  out  1  state != IDLE
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write strobe
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid with mem_ack
mem_ack  in  1  one-cycle memory completion

Behaviour:
- Clock and reset: one clock `clk`. `rst` is asynchronous and active-low.
- Reset values:
  - State = IDLE; BPR = 0; all cache valid bits = 0.
  - All outputs 0, including cpu_rdata and mem_addr.
  - Reset mid-operation drops mem_req immediately (asynchronously). No cpu_ack is issued for an aborted access.
- FSM states: IDLE, WALK, ACCESS, RESP.
- IDLE:
  - On cpu_req=1, latch we, vaddr, wdata.
  - If pg_en=0: physical address = vaddr[AW-1:0]; go to ACCESS.
  - If pg_en=1 and cache[vpn] is valid: use the cached PTE.
    - Fault check passes: go to ACCESS.
    - Fault check fails: go to RESP with fault.
  - If pg_en=1 and cache[vpn] is invalid: go to WALK.
- WALK:
  - mem_req=1, mem_we=0.
  - mem_addr = {BPR[AW-VPN_W-1:0], vpn}, i.e. BPR-latched base concatenated with VPN.
  - On mem_ack, capture mem_rdata as the PTE.
    - If PTE[0]=1, write it into cache[vpn].
    - Fault check passes: go to ACCESS.
    - Fault check fails: go to RESP with fault.
- Fault check:
  - PTE[0]=0 (not present) → fault.
  - cpu_we=1 and PTE[1]=0 (read-only) → fault.
- ACCESS:
  - mem_req=1, mem_we=latched we, mem_wdata=latched wdata.
  - Paged address: mem_addr = zero-extended {PTE[PPN_W+1:2], vaddr[OFF_W-1:0]}.
  - Unpaged address: vaddr[AW-1:0].
  - On mem_ack, register mem_rdata (reads only; writes leave cpu_rdata unchanged) and go to RESP.
- RESP:
  - cpu_ack=1 for exactly one cycle; cpu_fault=1 only if the access faulted, otherwise 0.
  - Next state is IDLE. A new request is not accepted until IDLE, so a held cpu_req re-issues one cycle later; the CPU must drop req on ack.
- Memory handshake:
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1.
  - mem_req deasserts the cycle after mem_ack.
  - mem_ack in the same cycle as mem_req rises is legal (zero wait). mem_ack outside a request is ignored.
- Latency, zero-wait memory, req sampled at cycle 0:
  - Unpaged or cache hit: ACCESS at cycle 1, cpu_ack at cycle 2.
  - Cache miss: WALK at 1, ACCESS at 2, cpu_ack at 3.
  - Hit fault: cpu_ack+fault at cycle 1.
  - Miss fault: cpu_ack+fault at 2.
  - Each memory wait state adds one cycle.
- Flush: bpr_load=1, or any change of pg_en, clears all valid bits at the next edge.
  - Flush takes priority over a simultaneous cache fill.
  - An in-flight walk completes using the address already issued, but its PTE is not cached.
  - BPR updates on bpr_load in any state. A walk already issued keeps its mem_addr (base latched at WALK entry).
- pg_en is sampled only in IDLE; changing it mid-access does not alter the current access's translation.
- Widths: the PTE table index wraps within BPR's low AW-VPN_W bits. Physical addresses are zero-extended to AW; vaddr bits above OFF_W+VPN_W are ignored when paging.

Test Plan:
- Unpaged read: pg_en=0, cpu_vaddr=0x0123, mem_rdata=0xBEEF zero-wait → mem_addr=0x0123 at cycle 1, cpu_ack with cpu_rdata=0xBEEF at cycle 2, no fault.
- Miss then hit: BPR=0x0005, pg_en=1, read vaddr=0x0027 (vpn=2, off=7) with PTE word 0x0037 (ppn=0xD, W=1, V=1) → WALK mem_addr=0x0016, ACCESS mem_addr=0x00D7, ack at cycle 3. Repeating the read gives no WALK and ack at cycle 2.
- Faults: PTE=0x0000 → cpu_ack with cpu_fault=1 and no ACCESS request, and the entry stays uncached. PTE=0x0035 with cpu_we=1 → write-protect fault; a subsequent read of the same page hits and succeeds.
- Flush: after cache fill, pulse bpr_load with 0x0009 → next access to the same vpn walks at mem_addr=0x0026. Also pulse bpr_load during WALK → the walk completes, the entry is not cached, and the next access walks again.
- Wait states and reset: mem_ack delayed 3 cycles → mem_req and mem_addr stay stable, and cpu_ack arrives exactly 3 cycles later. Assert rst in ACCESS → mem_req=0 immediately, no cpu_ack, cache invalid, BPR=0.
